// File: rtl/ernic_exdes_pkg.sv
// Shared constants and types for the ERNIC example-design datapath blocks.
package ernic_exdes_pkg;

    localparam int AXIS_DATA_W = 512;
    localparam int CNT_W       = 16;
    localparam int SRC_ID_W    = 3;

    // Requester identities on the shared CMAC TX port
    typedef enum logic [SRC_ID_W-1:0] {
        SRC_ERNIC   = 3'd0,
        SRC_NONROCE = 3'd1,
        SRC_GEN     = 3'd2
    } src_id_e;

    // Arbiter packet-level states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_DRAIN
    } arb_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/cmac_tx_pkt_arbiter_rr_pick.sv
// Combinational round-robin finder: first requester strictly after ptr, wrapping.
module rr_pick
    import ernic_exdes_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]        req,
    input  logic [SRC_ID_W-1:0] ptr,
    output logic [SRC_ID_W-1:0] idx,
    output logic                found
);

    // Scan offsets 1..N from the pointer; the pointer itself is checked last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (j == ((int'(ptr) + i) % N))) begin
                    found = 1'b1;
                    idx   = SRC_ID_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/cmac_tx_pkt_arbiter.sv
// Packet-atomic round-robin arbiter sharing the CMAC TX AXI-Stream port,
// with max-length truncation and per-source packet/error counters.
module cmac_tx_pkt_arbiter
    import ernic_exdes_pkg::*;
#(
    parameter int NUM_SRC   = 3,
    parameter int DATA_W    = AXIS_DATA_W,
    parameter int KEEP_W    = DATA_W / 8,
    parameter int MAX_BEATS = 160
) (
    input  logic                       cmac_tx_clk,
    input  logic                       cmac_rst,
    input  logic [NUM_SRC*DATA_W-1:0]  s_axis_tdata,
    input  logic [NUM_SRC*KEEP_W-1:0]  s_axis_tkeep,
    input  logic [NUM_SRC-1:0]         s_axis_tlast,
    input  logic [NUM_SRC-1:0]         s_axis_tvalid,
    output logic [NUM_SRC-1:0]         s_axis_tready,
    output logic [DATA_W-1:0]          m_axis_tdata,
    output logic [KEEP_W-1:0]          m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tuser,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    input  logic [NUM_SRC-1:0]         cfg_src_en,
    output logic [SRC_ID_W-1:0]        grant_id,
    output logic                       busy,
    output logic [NUM_SRC*CNT_W-1:0]   pkt_cnt,
    output logic [NUM_SRC*CNT_W-1:0]   err_cnt
);

    localparam int                BEAT_W   = 12;
    localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(MAX_BEATS - 1);

    arb_state_e                     state;
    arb_state_e                     state_nxt;
    logic [SRC_ID_W-1:0]            grant;
    logic [SRC_ID_W-1:0]            grant_nxt;
    logic [SRC_ID_W-1:0]            rr_ptr;
    logic [BEAT_W-1:0]              beat_cnt;
    logic [NUM_SRC-1:0][CNT_W-1:0]  pkt_q;
    logic [NUM_SRC-1:0][CNT_W-1:0]  err_q;

    logic [NUM_SRC-1:0]             eligible;
    logic [SRC_ID_W-1:0]            pick_idx;
    logic                           pick_found;

    logic                           g_valid;
    logic                           g_last;
    logic [DATA_W-1:0]              g_data;
    logic [KEEP_W-1:0]              g_keep;

    logic                           at_limit;
    logic                           xfer;
    logic                           pkt_done;
    logic                           trunc;

    assign eligible = s_axis_tvalid & cfg_src_en;

    rr_pick #(
        .N (NUM_SRC)
    ) u_rr_pick (
        .req   (eligible),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Mux the granted source's stream; a compare loop avoids a wide variable index.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        g_keep  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant == SRC_ID_W'(i)) begin
                g_valid = s_axis_tvalid[i];
                g_last  = s_axis_tlast[i];
                g_data  = s_axis_tdata[i*DATA_W +: DATA_W];
                g_keep  = s_axis_tkeep[i*KEEP_W +: KEEP_W];
            end
        end
    end

    // The MAX_BEATS-th beat is the one where the counter already holds MAX_BEATS-1.
    assign at_limit = (beat_cnt == LAST_IDX);
    assign xfer     = (state == ST_PASS) && g_valid && m_axis_tready;
    assign pkt_done = xfer && g_last;
    assign trunc    = xfer && !g_last && at_limit;

    // FSM state register.
    always_ff @(posedge cmac_tx_clk or posedge cmac_rst) begin
        if (cmac_rst) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic and the zero-latency passthrough / drain handshakes.
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_nxt = pick_idx;
                    state_nxt = ST_PASS;
                end
            end
            ST_PASS: begin
                m_axis_tvalid = g_valid;
                m_axis_tdata  = g_data;
                m_axis_tkeep  = g_keep;
                m_axis_tlast  = g_last | at_limit;
                m_axis_tuser  = at_limit & ~g_last;
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (grant == SRC_ID_W'(i)) s_axis_tready[i] = m_axis_tready;
                end
                if (pkt_done)   state_nxt = ST_IDLE;
                else if (trunc) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (grant == SRC_ID_W'(i)) s_axis_tready[i] = 1'b1;
                end
                if (g_valid && g_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Hold the grant for the whole packet, advance the rr pointer on admission, count beats.
    always_ff @(posedge cmac_tx_clk or posedge cmac_rst) begin
        if (cmac_rst) begin
            grant    <= SRC_ERNIC;
            rr_ptr   <= SRC_ID_W'(NUM_SRC - 1);
            beat_cnt <= '0;
        end else begin
            grant <= grant_nxt;
            if (state == ST_IDLE && pick_found) rr_ptr <= pick_idx;
            if (pkt_done || trunc) beat_cnt <= '0;
            else if (xfer)         beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Saturating per-source counters for completed and truncated packets.
    always_ff @(posedge cmac_tx_clk or posedge cmac_rst) begin
        if (cmac_rst) begin
            pkt_q <= '0;
            err_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant == SRC_ID_W'(i) && pkt_done) pkt_q[i] <= sat_inc(pkt_q[i]);
                if (grant == SRC_ID_W'(i) && trunc)    err_q[i] <= sat_inc(err_q[i]);
            end
        end
    end

    assign grant_id = grant;
    assign busy     = (state != ST_IDLE);
    assign pkt_cnt  = pkt_q;
    assign err_cnt  = err_q;

endmodule

// File: tb/tb_cmac_tx_pkt_arbiter.sv
// Scoreboard bench for cmac_tx_pkt_arbiter: per-source beat queues feed the DUT,
// expected CMAC beats are queued as stimulus is issued and popped on each transfer.
module tb_cmac_tx_pkt_arbiter;

    localparam int NS   = 3;
    localparam int DW   = 32;
    localparam int KW   = 4;
    localparam int MAXB = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef logic [DW+KW+1:0] exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NS*DW-1:0]  s_axis_tdata;
    logic [NS*KW-1:0]  s_axis_tkeep;
    logic [NS-1:0]     s_axis_tlast;
    logic [NS-1:0]     s_axis_tvalid;
    logic [NS-1:0]     s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tlast;
    logic              m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [NS-1:0]     cfg_src_en;
    logic [2:0]        grant_id;
    logic              busy;
    logic [NS*16-1:0]  pkt_cnt;
    logic [NS*16-1:0]  err_cnt;

    beat_t q0[$];
    beat_t q1[$];
    beat_t q2[$];
    exp_t  exp_q[$];
    int    cyc_log[$];

    int          errors    = 0;
    int          checks    = 0;
    int          cyc       = 0;
    int          out_beats = 0;
    int          next_id   = 1;
    logic [NS-1:0] hs      = '0;
    logic        bp_mode   = 1'b0;
    logic        bp_watch  = 1'b0;
    logic        bp_bad    = 1'b0;
    logic        en_watch  = 1'b0;
    logic        en_bad    = 1'b0;
    logic [15:0] model_pkt [NS];
    logic [15:0] model_err [NS];

    cmac_tx_pkt_arbiter #(
        .NUM_SRC   (NS),
        .DATA_W    (DW),
        .KEEP_W    (KW),
        .MAX_BEATS (MAXB)
    ) dut (
        .cmac_tx_clk   (clk),
        .cmac_rst      (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .cfg_src_en    (cfg_src_en),
        .grant_id      (grant_id),
        .busy          (busy),
        .pkt_cnt       (pkt_cnt),
        .err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Beat payload encodes source, packet id and beat number so ordering errors show up.
    function automatic beat_t mkBeat(input int s, input int id, input int b, input int n);
        beat_t r;
        r.data = {4'(s), 12'(id), 16'(b)};
        r.keep = (b == n) ? 4'h3 : 4'hF;
        r.last = (b == n);
        return r;
    endfunction

    function automatic int qSize(input int s);
        case (s)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic beat_t qHead(input int s);
        beat_t b = '0;
        case (s)
            0:       if (q0.size() > 0) b = q0[0];
            1:       if (q1.size() > 0) b = q1[0];
            default: if (q2.size() > 0) b = q2[0];
        endcase
        return b;
    endfunction

    task automatic qPop(input int s);
        case (s)
            0:       if (q0.size() > 0) void'(q0.pop_front());
            1:       if (q1.size() > 0) void'(q1.pop_front());
            default: if (q2.size() > 0) void'(q2.pop_front());
        endcase
    endtask

    // Queue a packet of n beats on source s.
    task automatic applyStimulus(input int s, input int id, input int n);
        for (int b = 1; b <= n; b++) begin
            case (s)
                0:       q0.push_back(mkBeat(s, id, b, n));
                1:       q1.push_back(mkBeat(s, id, b, n));
                default: q2.push_back(mkBeat(s, id, b, n));
            endcase
        end
    endtask

    // Push the CMAC-side beats this packet should produce and update the counter model.
    task automatic expectPacket(input int s, input int id, input int n);
        int emit;
        emit = (n > MAXB) ? MAXB : n;
        for (int b = 1; b <= emit; b++) begin
            beat_t r;
            logic  lst;
            logic  usr;
            r   = mkBeat(s, id, b, n);
            lst = (b == emit);
            usr = (n > MAXB) && (b == MAXB);
            exp_q.push_back({r.data, r.keep, lst, usr});
        end
        if (n > MAXB) begin
            if (model_err[s] != 16'hFFFF) model_err[s] = model_err[s] + 16'd1;
        end else begin
            if (model_pkt[s] != 16'hFFFF) model_pkt[s] = model_pkt[s] + 16'd1;
        end
    endtask

    // Wait until every expected beat has appeared and the arbiter is idle again.
    task automatic waitDrain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_done", 64'(exp_q.size() == 0 && !busy), 64'(1));
    endtask

    task automatic waitBeats(input int target, input int budget);
        int n = 0;
        while (out_beats < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("beats_seen", 64'(out_beats >= target), 64'(1));
    endtask

    task automatic checkCounters(input string tag);
        for (int s = 0; s < NS; s++) begin
            checkOutput($sformatf("%s_pkt%0d", tag, s), 64'(pkt_cnt[s*16 +: 16]), 64'(model_pkt[s]));
            checkOutput($sformatf("%s_err%0d", tag, s), 64'(err_cnt[s*16 +: 16]), 64'(model_err[s]));
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_s_tready"}, 64'(s_axis_tready), 64'(0));
        checkOutput({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'(0));
        checkOutput({tag, "_m_tlast"},  64'(m_axis_tlast),  64'(0));
        checkOutput({tag, "_m_tuser"},  64'(m_axis_tuser),  64'(0));
        checkOutput({tag, "_grant"},    64'(grant_id),      64'(0));
        checkOutput({tag, "_busy"},     64'(busy),          64'(0));
        checkOutput({tag, "_pkt_cnt"},  64'(pkt_cnt),       64'(0));
        checkOutput({tag, "_err_cnt"},  64'(err_cnt),       64'(0));
    endtask

    // Source drivers: retire beats that handshook last cycle, then present queue heads.
    initial begin
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (hs[i]) qPop(i);
            end
            if (bp_mode) m_axis_tready = ~m_axis_tready;
            else         m_axis_tready = 1'b1;
            for (int i = 0; i < NS; i++) begin
                beat_t b;
                b = qHead(i);
                s_axis_tvalid[i]             = (qSize(i) > 0);
                s_axis_tdata[i*DW +: DW]     = b.data;
                s_axis_tkeep[i*KW +: KW]     = b.keep;
                s_axis_tlast[i]              = b.last;
            end
        end
    end

    // Mid-cycle monitor: records source handshakes and scores every CMAC transfer.
    always @(negedge clk) begin
        cyc++;
        hs = s_axis_tvalid & s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) begin
            out_beats++;
            cyc_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                checkOutput("beat_expected", 64'(exp_q.size()), 64'(1));
            end else begin
                checkOutput("beat", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}),
                            64'(exp_q.pop_front()));
            end
        end
        if (bp_watch && (s_axis_tready[0] || s_axis_tready[2])) bp_bad = 1'b1;
        if (en_watch && busy && grant_id == 3'd0) en_bad = 1'b1;
    end

    // Bound the whole run so a stuck DUT still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios in sequence.
    initial begin
        int base;
        int idc;
        cfg_src_en = '1;
        for (int s = 0; s < NS; s++) begin
            model_pkt[s] = 16'd0;
            model_err[s] = 16'd0;
        end

        repeat (3) @(negedge clk);
        checkResetState("reset");
        @(posedge clk);
        #2 rst = 1'b0;

        // Fairness: all sources loaded; pointer starts at NUM_SRC-1 so order is 0,1,2,...
        for (int p = 0; p < 4; p++) begin
            for (int s = 0; s < NS; s++) begin
                applyStimulus(s, next_id, 2);
                expectPacket(s, next_id, 2);
                next_id++;
            end
        end
        waitDrain(300);
        checkCounters("fair");

        // Single source, three back-to-back 4-beat packets with a single idle cycle between.
        base = cyc_log.size();
        for (int p = 0; p < 3; p++) begin
            applyStimulus(0, next_id, 4);
            expectPacket(0, next_id, 4);
            next_id++;
        end
        waitDrain(200);
        checkOutput("single_beats", 64'(cyc_log.size() - base), 64'(12));
        if (cyc_log.size() >= base + 12)
            checkOutput("single_span", 64'(cyc_log[base+11] - cyc_log[base]), 64'(13));
        checkCounters("single");

        // Backpressure on a 5-beat src1 packet.
        bp_watch = 1'b1;
        bp_mode  = 1'b1;
        applyStimulus(1, next_id, 5);
        expectPacket(1, next_id, 5);
        next_id++;
        waitDrain(200);
        bp_mode  = 1'b0;
        bp_watch = 1'b0;
        checkOutput("bp_other_ready", 64'(bp_bad), 64'(0));
        checkCounters("bp");

        // Truncation of a 12-beat packet, then an exactly-MAX_BEATS packet.
        applyStimulus(2, next_id, 12);
        expectPacket(2, next_id, 12);
        next_id++;
        waitDrain(200);
        checkOutput("drain_sunk", 64'(qSize(2)), 64'(0));
        applyStimulus(2, next_id, MAXB);
        expectPacket(2, next_id, MAXB);
        next_id++;
        waitDrain(200);
        checkCounters("trunc");

        // Enable cleared mid-packet: packet finishes, src0 then stays ungranted.
        base = out_beats;
        applyStimulus(0, next_id, 6);
        expectPacket(0, next_id, 6);
        next_id++;
        waitBeats(base + 1, 50);
        @(posedge clk);
        #2 cfg_src_en[0] = 1'b0;
        applyStimulus(1, next_id, 2);
        expectPacket(1, next_id, 2);
        next_id++;
        idc = next_id;
        next_id++;
        applyStimulus(0, idc, 2);
        waitBeats(base + 6, 50);
        @(posedge clk);
        #2 en_watch = 1'b1;
        waitDrain(200);
        repeat (10) @(negedge clk);
        en_watch = 1'b0;
        checkOutput("en_src0_held_off", 64'(en_bad), 64'(0));
        cfg_src_en[0] = 1'b1;
        expectPacket(0, idc, 2);
        waitDrain(200);
        checkCounters("enable");

        // Reset mid-packet: immediate abort; the rest of the packet goes out as a new one.
        base = out_beats;
        applyStimulus(1, next_id, 6);
        expectPacket(1, next_id, 6);
        next_id++;
        waitBeats(base + 3, 50);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 checkResetState("rst_mid");
        for (int s = 0; s < NS; s++) begin
            model_pkt[s] = 16'd0;
            model_err[s] = 16'd0;
        end
        model_pkt[1] = 16'd1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        waitDrain(200);
        checkCounters("post_rst");

        // Saturation: preload src0 near the top, then complete three one-beat packets.
        @(negedge clk);
        force dut.pkt_q = {16'h0000, 16'h0001, 16'hFFFE};
        model_pkt[0] = 16'hFFFE;
        @(negedge clk);
        release dut.pkt_q;
        for (int p = 0; p < 3; p++) begin
            applyStimulus(0, next_id, 1);
            expectPacket(0, next_id, 1);
            next_id++;
        end
        waitDrain(100);
        checkCounters("sat");

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmac_tx_pkt_arbiter.md
Name: cmac_tx_pkt_arbiter

Overview:
Packet-atomic round-robin arbiter that shares the single CMAC TX AXI-Stream port between NUM_SRC requesters: ERNIC RoCE egress, the non-RoCE/ARP path and the exdes traffic generator. It sits in the cmac_tx_clk domain between the requesters and the CMAC TX interface. It enforces a maximum packet length and keeps per-source packet and error counters that the exdes status logic reads alongside the num_* counters.

Parameters:
NUM_SRC, 3, number of requesting sources (2..8); source 0 = ERNIC
DATA_W, 512, tdata width in bits
KEEP_W, DATA_W/8, tkeep width
MAX_BEATS, 160, maximum beats per packet before forced termination (1..4095)

Ports:
cmac_tx_clk  in  1  sole clock
cmac_rst  in  1  asynchronous, active-high reset
s_axis_tdata  in  NUM_SRC*DATA_W  source data, source i at slice i
s_axis_tkeep  in  NUM_SRC*KEEP_W  source byte enables
s_axis_tlast  in  NUM_SRC  end of packet
s_axis_tvalid  in  NUM_SRC  source valid
s_axis_tready  out  NUM_SRC  source ready
m_axis_tdata  out  DATA_W  to CMAC TX
m_axis_tkeep  out  KEEP_W
m_axis_tlast  out  1
m_axis_tuser  out  1  packet error flag, valid on the last beat only
m_axis_tvalid  out  1
m_axis_tready  in  1
cfg_src_en  in  NUM_SRC  per-source arbitration enable
grant_id  out  3  currently granted source
busy  out  1  high in PASS or DRAIN
pkt_cnt  out  NUM_SRC*16  packets forwarded per source, saturating
err_cnt  out  NUM_SRC*16  forced-truncation events per source, saturating

Behaviour:
- Reset values: all s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, grant_id=0, busy=0, pkt_cnt=0, err_cnt=0, beat counter=0, rr pointer=NUM_SRC-1, state=IDLE. Asserting reset mid-packet aborts immediately with no flush. After release, a source that was mid-packet starts fresh and its remaining beats are forwarded as a new packet.
- State machine:
  - IDLE: eligible = tvalid & cfg_src_en. If any source is eligible, register grant = first eligible source after the rr pointer (cyclic), set rr pointer = grant, go to PASS. Always exactly one idle cycle between packets.
  - PASS: combinational passthrough of the granted source. m_axis_tvalid = s_tvalid[g]; s_tready[g] = m_tready; all other tready = 0. tdata, tkeep and tlast are muxed from g; tuser = 0.
    - Beat counter increments on each transfer (tvalid & tready).
    - Transfer with tlast: pkt_cnt[g]++ and go to IDLE.
    - Transfer where the counter reaches MAX_BEATS without tlast: force m_axis_tlast=1 and m_axis_tuser=1 on that beat, err_cnt[g]++, and go to DRAIN. pkt_cnt is not incremented.
  - DRAIN: s_tready[g]=1, m_axis_tvalid=0. Source beats are discarded until a transfer with tlast, then go to IDLE.
- Grants are packet-atomic. Clearing cfg_src_en[g] mid-packet has no effect until the packet ends. tvalid dropping mid-packet holds the grant indefinitely.
- A tlast arriving exactly on beat MAX_BEATS is a normal packet: no tuser, no DRAIN.
- Counters are 16-bit and saturate at 0xFFFF with no wrap.
- No output registering; source-to-CMAC latency is 0 cycles within PASS.

Decomposition:
- Shared package ernic_exdes_pkg: AXIS width constants, the source-index enum (SRC_ERNIC=0, SRC_NONROCE=1, SRC_GEN=2), and the counter width constant 16.
- One sub-module, rr_pick: combinational round-robin first-eligible finder (request vector + pointer -> index + found). Counters and the FSM stay in the top module.

Test Plan:
- Single source: src0 sends 3 packets of 4 beats with m_tready=1 -> outputs match bit-exact, a 1-cycle gap between packets, pkt_cnt[0]=3, err_cnt=0.
- Fairness: all 3 sources continuously valid with 2-beat packets for 12 packets -> grant order 0,1,2,0,1,2…; pkt_cnt = 4,4,4.
- Backpressure: m_tready toggled 1/0 every cycle during a 5-beat src1 packet -> no beat lost or duplicated; src0 and src2 tready stay 0 throughout.
- Truncation: MAX_BEATS=8; src2 sends a 12-beat packet -> beat 8 is emitted with tlast=1 and tuser=1, beats 9-12 are sunk with no m_tvalid, err_cnt[2]=1, pkt_cnt[2]=0. A separate 8-beat packet completes normally.
- Enable change: clear cfg_src_en[0] during beat 2 of a 6-beat src0 packet -> all 6 beats are forwarded and src0 is not granted afterwards while src1 is valid.
- Saturation and reset: preload via 65537 one-beat packets (or a force) -> pkt_cnt holds 0xFFFF. Assert cmac_rst mid-packet -> all outputs return to reset values immediately.
